stream_demux_1_n: RTL and testbench
===================================

Name: stream_demux_1_n

Overview:
- Registered, parametrised 1-to-N stream demultiplexer. It generalises the team's combinational 1-to-4 demux to CHANNELS outputs, WIDTH-bit data and valid/ready handshaking on every port.
- Each output channel has a one-entry holding register.
- Two steering modes: explicit select, or hardware round-robin distribution.
- Sits between a single producer and N independent consumers, for example a work dispatcher feeding parallel processing lanes.

Parameters:
- WIDTH, 8, data width in bits of in_data and of each output lane.
- CHANNELS, 4, number of output channels, 2..16.
- SEL_W, 2, width of in_sel and rr_ptr; must satisfy 2**SEL_W >= CHANNELS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = steer by in_sel; 1 = round-robin.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  WIDTH  beat payload.
- in_sel  input  SEL_W  target channel, used when mode=0.
- out_valid  output  CHANNELS  per-channel beat present.
- out_ready  input  CHANNELS  per-channel consumer accepts.
- out_data  output  CHANNELS*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- rr_ptr  output  SEL_W  next round-robin target.
- busy  output  1  OR of out_valid.

Behaviour:
- Reset (asynchronous, rst_n=0): out_valid=0, out_data=0, rr_ptr=0, busy=0. Any held beats are discarded. Outputs stay at these values until the first rising clk after rst_n deasserts.
- Target selection:
  - tgt = in_sel when mode=0; tgt = rr_ptr when mode=1.
  - tgt is combinational from the current mode, in_sel and rr_ptr.
- Input handshake:
  - in_ready = invalid(tgt) | ~out_valid[tgt] | out_ready[tgt].
  - in_ready depends on out_ready, which is an allowed combinational path.
  - invalid(tgt) means tgt >= CHANNELS.
  - A beat is accepted when in_valid & in_ready.
- Channel register i:
  - Drain: out_valid[i] & out_ready[i]. Load: accept & tgt==i & tgt valid.
  - Load (with or without drain): out_valid[i]<=1, lane i <= in_data. Latency is 1 cycle from accept to out_valid.
  - Drain without load: out_valid[i]<=0, lane i <= 0. Unselected or empty lanes always read 0, matching the 1-to-4 demux.
  - Neither: hold.
  - Simultaneous drain and load on the same channel gives full throughput: 1 beat per cycle per channel.
- Out-of-range target (tgt >= CHANNELS, only possible when CHANNELS is not a power of two):
  - The beat is accepted and dropped.
  - No channel changes.
  - rr_ptr does not advance, since it can never hold an out-of-range value in mode=1.
- Round-robin:
  - In mode=1, each accept advances rr_ptr by 1 and wraps from CHANNELS-1 to 0.
  - If the target channel is full and not draining, in_ready=0 and rr_ptr holds. Strict order, no skipping.
  - In mode=0, rr_ptr holds its value and is never cleared by a mode change.
- Mode change:
  - Combinational effect on tgt in the same cycle.
  - Held beats are unaffected.
- Output channels are independent; a stalled channel never blocks other channels in mode=0.
- busy = |out_valid, registered-equivalent (derived from flops only).
- in_data and in_sel are ignored when in_valid=0.
- X on in_sel with in_valid=0 must not corrupt state.

Optional Feature:
- Macro DEMUX_DROP_CNT_EN.
- Defined:
  - Adds ports drop_clr input 1 and drop_cnt output 16.
  - drop_cnt resets to 0 and increments on each dropped out-of-range beat, saturating at 16'hFFFF.
  - drop_clr=1 synchronously clears it to 0. Clear wins over a simultaneous increment.
- Undefined:
  - Ports and counter are absent.
  - Out-of-range beats are still accepted and dropped silently.

Test Plan:
- Reset mid-traffic: load 0xA5 to ch2, hold out_ready=0, pulse rst_n low between clock edges -> out_valid=0000, lane2=0x00 and rr_ptr=0 immediately, before the next clk edge.
- Explicit steering: mode=0, in_sel=0,1,2,3 with data 0x11,0x22,0x33,0x44, all out_ready=1 -> each out_valid[i] pulses one cycle after its accept with the matching data. in_ready stays 1 throughout and lanes return to 0 after drain.
- Backpressure: mode=0, in_sel=1, out_ready[1]=0, send 0x5A then 0x6B -> 0x5A held on lane1 and in_ready=0 for the second beat. Meanwhile in_sel=3 with 0x7C is accepted and appears on lane3. Raise out_ready[1] -> 0x6B accepted in the same cycle 0x5A drains.
- Round-robin wrap: mode=1, all ready, 6 beats 0x01..0x06 -> channels 0,1,2,3,0,1 receive them in order and rr_ptr ends at 2. Stall ch2 (out_ready[2]=0, ch2 occupied) -> in_ready=0 and rr_ptr stays at 2 until ch2 drains.
- Full throughput: mode=0, in_sel=0, in_valid=1 and out_ready[0]=1 for 8 cycles, data 0..7 -> 8 beats out on 8 consecutive cycles, no bubbles.
- Drop counter (CHANNELS=3, SEL_W=2, DEMUX_DROP_CNT_EN defined): mode=0, in_sel=3 for 5 beats -> in_ready=1, no out_valid, drop_cnt=5. Assert drop_clr together with a 6th drop -> drop_cnt=0.

Source files
------------

// File: rtl/stream_demux_1_n.sv
// stream_demux_1_n: registered 1-to-N valid/ready stream demultiplexer.
// Each output channel owns a one-entry holding register. The target is picked
// either by in_sel (mode=0) or by an internal round-robin pointer (mode=1).
// Beats aimed at a channel index >= CHANNELS are accepted and dropped.
// Optional feature macro: DEMUX_DROP_CNT_EN adds drop_clr/drop_cnt, a
// saturating count of dropped out-of-range beats.
module stream_demux_1_n #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]          rr_ptr,
  output logic                      busy
`ifdef DEMUX_DROP_CNT_EN
  ,
  input  logic                      drop_clr,
  output logic [15:0]               drop_cnt
`endif
);

  localparam int unsigned DATA_W = CHANNELS * WIDTH;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0]    tgt_c;
  logic [CHANNELS-1:0] tgt_oh_c;
  logic                tgt_ok_c;
  logic                accept_c;
  logic [CHANNELS-1:0] load_c;
  logic [CHANNELS-1:0] drain_c;
  logic [CHANNELS-1:0] out_valid_nxt_c;
  logic [DATA_W-1:0]   out_data_nxt_c;
  logic [SEL_W-1:0]    rr_ptr_nxt_c;

  // Target channel: explicit select or round-robin pointer
  always_comb begin
    tgt_c = in_sel;
    if (mode) begin
      tgt_c = rr_ptr;
    end
  end

  // One-hot decode of the target; an all-zero result marks an out-of-range target
  always_comb begin
    tgt_oh_c = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (tgt_c == SEL_W'(i)) begin
        tgt_oh_c[i] = 1'b1;
      end
    end
  end

  // Input handshake: out-of-range beats are always taken, otherwise the target must have room
  always_comb begin
    tgt_ok_c = |tgt_oh_c;
    in_ready = ~tgt_ok_c | (|(tgt_oh_c & (~out_valid | out_ready)));
    accept_c = in_valid & in_ready;
    load_c   = {CHANNELS{accept_c}} & tgt_oh_c;
    drain_c  = out_valid & out_ready;
  end

  // Next state of each holding register: load wins, a bare drain clears the lane to zero
  always_comb begin
    out_valid_nxt_c = out_valid;
    out_data_nxt_c  = out_data;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (load_c[i]) begin
        out_valid_nxt_c[i]                = 1'b1;
        out_data_nxt_c[i*WIDTH +: WIDTH] = in_data;
      end else if (drain_c[i]) begin
        out_valid_nxt_c[i]                = 1'b0;
        out_data_nxt_c[i*WIDTH +: WIDTH] = '0;
      end
    end
  end

  // Round-robin pointer advances only on an accepted in-range beat in mode=1
  always_comb begin
    rr_ptr_nxt_c = rr_ptr;
    if (mode && accept_c && tgt_ok_c) begin
      if (rr_ptr == LAST_CH) begin
        rr_ptr_nxt_c = '0;
      end else begin
        rr_ptr_nxt_c = rr_ptr + SEL_W'(1);
      end
    end
  end

  // Channel holding registers and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else begin
      out_valid <= out_valid_nxt_c;
      out_data  <= out_data_nxt_c;
      rr_ptr    <= rr_ptr_nxt_c;
    end
  end

  // Activity flag is a pure function of the channel flops
  assign busy = |out_valid;

`ifdef DEMUX_DROP_CNT_EN
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic drop_c;

  // A dropped beat is one accepted while the target is out of range
  assign drop_c = accept_c & ~tgt_ok_c;

  // Saturating drop counter; clear has priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop_clr) begin
      drop_cnt <= '0;
    end else if (drop_c && (drop_cnt != CNT_MAX)) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux_1_n.sv
// Directed bench for stream_demux_1_n: a 4-channel instance for steering,
// backpressure, round-robin, throughput and reset; a 3-channel instance for
// out-of-range drops (and drop_cnt when DEMUX_DROP_CNT_EN is defined).
module tb_stream_demux_1_n;

  logic clk;
  logic rst_n;

  // 4-channel instance
  logic        a_mode;
  logic        a_in_valid;
  logic        a_in_ready;
  logic [7:0]  a_in_data;
  logic [1:0]  a_in_sel;
  logic [3:0]  a_out_valid;
  logic [3:0]  a_out_ready;
  logic [31:0] a_out_data;
  logic [1:0]  a_rr_ptr;
  logic        a_busy;

  // 3-channel instance
  logic        b_mode;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [7:0]  b_in_data;
  logic [1:0]  b_in_sel;
  logic [2:0]  b_out_valid;
  logic [2:0]  b_out_ready;
  logic [23:0] b_out_data;
  logic [1:0]  b_rr_ptr;
  logic        b_busy;
`ifdef DEMUX_DROP_CNT_EN
  logic        a_drop_clr;
  logic [15:0] a_drop_cnt;
  logic        b_drop_clr;
  logic [15:0] b_drop_cnt;
`endif

  int total;
  int bad;

  stream_demux_1_n #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (a_mode),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .in_sel    (a_in_sel),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .rr_ptr    (a_rr_ptr),
    .busy      (a_busy)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_clr  (a_drop_clr),
    .drop_cnt  (a_drop_cnt)
`endif
  );

  stream_demux_1_n #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (b_mode),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_sel    (b_in_sel),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .rr_ptr    (b_rr_ptr),
    .busy      (b_busy)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_clr  (b_drop_clr),
    .drop_cnt  (b_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle (inputs change here)
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lane_a(input int i);
    return a_out_data[i*8 +: 8];
  endfunction

  function automatic logic [7:0] lane_b(input int i);
    return b_out_data[i*8 +: 8];
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a_mode = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_in_sel = '0; a_out_ready = '0;
    b_mode = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_sel = '0; b_out_ready = '0;
`ifdef DEMUX_DROP_CNT_EN
    a_drop_clr = 1'b0;
    b_drop_clr = 1'b0;
`endif
    #2;
    check("rst_out_valid", 32'(a_out_valid), 32'h0);
    check("rst_out_data", a_out_data, 32'h0);
    check("rst_rr_ptr", 32'(a_rr_ptr), 32'h0);
    check("rst_busy", 32'(a_busy), 32'h0);
    #10;
    rst_n = 1'b1;
    cyc();

    // Explicit steering, all consumers ready
    a_mode = 1'b0;
    a_out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      a_in_sel   = 2'(i);
      a_in_data  = 8'((i + 1) * 8'h11);
      a_in_valid = 1'b1;
      #1;
      check("steer_in_ready", 32'(a_in_ready), 32'h1);
      cyc();
      check("steer_out_valid", 32'(a_out_valid), 32'(4'b0001 << i));
      check("steer_lane", 32'(lane_a(i)), 32'((i + 1) * 8'h11));
      check("steer_busy", 32'(a_busy), 32'h1);
    end
    a_in_valid = 1'b0;
    cyc();
    check("steer_drained_valid", 32'(a_out_valid), 32'h0);
    check("steer_drained_data", a_out_data, 32'h0);
    check("steer_idle_busy", 32'(a_busy), 32'h0);

    // Backpressure on channel 1; channel 3 still flows
    a_out_ready = 4'b1101;
    a_in_sel = 2'd1; a_in_data = 8'h5A; a_in_valid = 1'b1;
    #1;
    check("bp_first_ready", 32'(a_in_ready), 32'h1);
    cyc();
    check("bp_held_valid", 32'(a_out_valid), 32'b0010);
    check("bp_held_lane1", 32'(lane_a(1)), 32'h5A);
    a_in_data = 8'h6B;
    #1;
    check("bp_second_stalled", 32'(a_in_ready), 32'h0);
    cyc();
    check("bp_still_held", 32'(lane_a(1)), 32'h5A);
    a_in_sel = 2'd3; a_in_data = 8'h7C;
    #1;
    check("bp_ch3_ready", 32'(a_in_ready), 32'h1);
    cyc();
    check("bp_ch3_valid", 32'(a_out_valid), 32'b1010);
    check("bp_ch3_lane", 32'(lane_a(3)), 32'h7C);
    a_in_sel = 2'd1; a_in_data = 8'h6B; a_out_ready = 4'hF;
    #1;
    check("bp_release_ready", 32'(a_in_ready), 32'h1);
    cyc();
    check("bp_swap_valid", 32'(a_out_valid), 32'b0010);
    check("bp_swap_lane1", 32'(lane_a(1)), 32'h6B);
    a_in_valid = 1'b0;
    cyc();
    check("bp_empty", 32'(a_out_valid), 32'h0);

    // Round-robin distribution with wrap
    a_mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a_in_data = 8'(k + 1);
      a_in_valid = 1'b1;
      #1;
      check("rr_ptr_before", 32'(a_rr_ptr), 32'(k % 4));
      cyc();
      check("rr_out_valid", 32'(a_out_valid), 32'(4'b0001 << (k % 4)));
      check("rr_lane", 32'(lane_a(k % 4)), 32'(k + 1));
    end
    check("rr_ptr_end", 32'(a_rr_ptr), 32'h2);

    // Occupy ch2 by explicit select, then stall round-robin on it
    a_mode = 1'b0; a_in_sel = 2'd2; a_in_data = 8'h77; a_out_ready = 4'b1011;
    cyc();
    check("rr_ptr_hold_mode0", 32'(a_rr_ptr), 32'h2);
    check("rr_ch2_occupied", 32'(lane_a(2)), 32'h77);
    a_mode = 1'b1; a_in_data = 8'h08;
    #1;
    check("rr_stall_ready", 32'(a_in_ready), 32'h0);
    cyc();
    cyc();
    check("rr_stall_ptr", 32'(a_rr_ptr), 32'h2);
    check("rr_stall_lane2", 32'(lane_a(2)), 32'h77);
    a_out_ready = 4'hF;
    #1;
    check("rr_unstall_ready", 32'(a_in_ready), 32'h1);
    cyc();
    check("rr_unstall_lane2", 32'(lane_a(2)), 32'h08);
    check("rr_unstall_ptr", 32'(a_rr_ptr), 32'h3);
    a_in_valid = 1'b0;
    cyc();

    // Full throughput on channel 0
    a_mode = 1'b0; a_in_sel = 2'd0;
    for (int d = 0; d < 8; d++) begin
      a_in_data = 8'(d);
      a_in_valid = 1'b1;
      #1;
      check("tput_ready", 32'(a_in_ready), 32'h1);
      cyc();
      check("tput_valid", 32'(a_out_valid), 32'b0001);
      check("tput_lane0", 32'(lane_a(0)), 32'(d));
    end
    a_in_valid = 1'b0;
    cyc();
    check("tput_drained", 32'(a_out_valid), 32'h0);

    // Reset mid-traffic, asserted between clock edges
    a_out_ready = 4'h0; a_in_sel = 2'd2; a_in_data = 8'hA5; a_in_valid = 1'b1;
    cyc();
    a_in_valid = 1'b0;
    check("mrst_pre_valid", 32'(a_out_valid), 32'b0100);
    check("mrst_pre_lane2", 32'(lane_a(2)), 32'hA5);
    check("mrst_pre_ptr", 32'(a_rr_ptr), 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(a_out_valid), 32'h0);
    check("mrst_lane2", 32'(lane_a(2)), 32'h0);
    check("mrst_ptr", 32'(a_rr_ptr), 32'h0);
    check("mrst_busy", 32'(a_busy), 32'h0);
    #3;
    rst_n = 1'b1;
    cyc();
    check("mrst_after_valid", 32'(a_out_valid), 32'h0);

    // 3-channel instance: out-of-range beats are accepted and dropped
    b_mode = 1'b0; b_in_sel = 2'd3; b_in_data = 8'h99; b_out_ready = 3'b111;
    for (int n = 0; n < 5; n++) begin
      b_in_valid = 1'b1;
      #1;
      check("drop_ready", 32'(b_in_ready), 32'h1);
      cyc();
      check("drop_no_valid", 32'(b_out_valid), 32'h0);
      check("drop_no_data", b_out_data, 32'h0);
    end
    check("drop_ptr", 32'(b_rr_ptr), 32'h0);
`ifdef DEMUX_DROP_CNT_EN
    check("drop_cnt5", 32'(b_drop_cnt), 32'd5);
    b_drop_clr = 1'b1;
    cyc();
    b_drop_clr = 1'b0;
    check("drop_clr_wins", 32'(b_drop_cnt), 32'd0);
`endif
    b_in_valid = 1'b0;
    cyc();

    // 3-channel round-robin wraps from 2 to 0
    b_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b_in_data = 8'(8'hC0 + k);
      b_in_valid = 1'b1;
      cyc();
      check("rr3_valid", 32'(b_out_valid), 32'(3'b001 << k));
      check("rr3_lane", 32'(lane_b(k)), 32'(8'hC0 + k));
      check("rr3_ptr", 32'(b_rr_ptr), 32'((k + 1) % 3));
    end
    b_in_valid = 1'b0;
    cyc();
    check("rr3_drained", 32'(b_out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
